crypt_stream_ctrl: RTL

- Command-framed bridge between the UART byte stream and a BLOCK_W-wide block cipher core.
- Replaces the fixed 8->64 / 64->8 FIFO adapter pair with four functions:
  - packs data bytes into blocks and unpacks cipher results back to bytes;
  - loads the cipher key at run time;
  - loads a CBC chaining value (IV);
  - selects ECB or CBC mode per block.
- Sits between uart (8-bit AXI-Stream) and the cipher core (BLOCK_W AXI-Stream plus key bus).

---
 rtl/crypt_stream_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/crypt_stream_ctrl.sv
// crypt_stream_ctrl: command-framed bridge between an 8-bit UART byte stream
// and a BLOCK_W-wide block cipher core.
//
// Commands (first byte of a frame, accepted in IDLE):
//   'K' + KEY_W/8 bytes   : load cipher key, answer 0x06
//   'I' + BLOCK_W/8 bytes : load CBC chaining value, answer 0x06
//   'E' + BLOCK_W/8 bytes : encrypt block in ECB mode, answer with result bytes
//   'C' + BLOCK_W/8 bytes : encrypt block in CBC mode, answer with result bytes
//   anything else         : answer 0x3F
// All multi-byte fields travel MSB-first in both directions.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_axis_*          command/data bytes from uart
//   m_axis_*          response bytes to uart
//   c_m_axis_*        block towards cipher core
//   c_s_axis_*        result from cipher core
//   key, key_update   current key and one-cycle pulse after it changes
module crypt_stream_ctrl #(
  parameter int unsigned BLOCK_W = 64,
  parameter int unsigned KEY_W   = 48,
  parameter logic [KEY_W-1:0]   INIT_KEY = '0,
  parameter logic [BLOCK_W-1:0] INIT_IV  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [7:0]         m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [BLOCK_W-1:0] c_m_axis_tdata,
  output logic               c_m_axis_tvalid,
  input  logic               c_m_axis_tready,
  input  logic [BLOCK_W-1:0] c_s_axis_tdata,
  input  logic               c_s_axis_tvalid,
  output logic               c_s_axis_tready,
  output logic [KEY_W-1:0]   key,
  output logic               key_update
);

  localparam int unsigned RxW      = (BLOCK_W > KEY_W) ? BLOCK_W : KEY_W;
  localparam int unsigned MaxBytes = RxW / 8;
  localparam int unsigned CntW     = (MaxBytes > 2) ? $clog2(MaxBytes) : 1;
  localparam logic [CntW-1:0] BlkLast = CntW'(BLOCK_W / 8 - 1);
  localparam logic [CntW-1:0] KeyLast = CntW'(KEY_W / 8 - 1);

  localparam logic [7:0] CmdKey  = 8'h4B;
  localparam logic [7:0] CmdIv   = 8'h49;
  localparam logic [7:0] CmdEcb  = 8'h45;
  localparam logic [7:0] CmdCbc  = 8'h43;
  localparam logic [7:0] CodeAck = 8'h06;
  localparam logic [7:0] CodeErr = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StRxKey,
    StRxIv,
    StRxBlk,
    StCiphSend,
    StCiphWait,
    StTxBlk,
    StTxAck
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  // Holds all but the newest byte of the field being received; the newest byte
  // is appended combinationally so the full field is usable on the last edge.
  logic [RxW-9:0]     rx_q, rx_d;
  logic [RxW-1:0]     rx_next;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               key_upd_q, key_upd_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] tx_q, tx_d;
  logic [7:0]         ack_q, ack_d;
  logic               cbc_q, cbc_d;
  logic               s_hs;

  assign rx_next = {rx_q, s_axis_tdata};
  assign s_hs    = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    key_d     = key_q;
    key_upd_d = 1'b0;
    chain_d   = chain_q;
    blk_d     = blk_q;
    tx_d      = tx_q;
    ack_d     = ack_q;
    cbc_d     = cbc_q;

    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          cnt_d = '0;
          unique case (s_axis_tdata)
            CmdKey: state_d = StRxKey;
            CmdIv:  state_d = StRxIv;
            CmdEcb: begin
              state_d = StRxBlk;
              cbc_d   = 1'b0;
            end
            CmdCbc: begin
              state_d = StRxBlk;
              cbc_d   = 1'b1;
            end
            default: begin
              state_d = StTxAck;
              ack_d   = CodeErr;
            end
          endcase
        end
      end

      StRxKey: begin
        if (s_hs) begin
          rx_d  = rx_next[RxW-9:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == KeyLast) begin
            key_d     = rx_next[KEY_W-1:0];
            key_upd_d = 1'b1;
            ack_d     = CodeAck;
            cnt_d     = '0;
            state_d   = StTxAck;
          end
        end
      end

      StRxIv: begin
        if (s_hs) begin
          rx_d  = rx_next[RxW-9:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == BlkLast) begin
            chain_d = rx_next[BLOCK_W-1:0];
            ack_d   = CodeAck;
            cnt_d   = '0;
            state_d = StTxAck;
          end
        end
      end

      StRxBlk: begin
        if (s_hs) begin
          rx_d  = rx_next[RxW-9:0];
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == BlkLast) begin
            blk_d   = rx_next[BLOCK_W-1:0] ^ (cbc_q ? chain_q : '0);
            cnt_d   = '0;
            state_d = StCiphSend;
          end
        end
      end

      StCiphSend: begin
        if (c_m_axis_tready) begin
          cnt_d   = '0;
          state_d = StCiphWait;
        end
      end

      StCiphWait: begin
        if (c_s_axis_tvalid) begin
          tx_d = c_s_axis_tdata;
          if (cbc_q) begin
            chain_d = c_s_axis_tdata;
          end
          cnt_d   = '0;
          state_d = StTxBlk;
        end
      end

      StTxBlk: begin
        if (m_axis_tready) begin
          tx_d  = tx_q << 8;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == BlkLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end

      StTxAck: begin
        if (m_axis_tready) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rx_q      <= '0;
      key_q     <= INIT_KEY;
      key_upd_q <= 1'b0;
      chain_q   <= INIT_IV;
      blk_q     <= '0;
      tx_q      <= '0;
      ack_q     <= '0;
      cbc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      key_q     <= key_d;
      key_upd_q <= key_upd_d;
      chain_q   <= chain_d;
      blk_q     <= blk_d;
      tx_q      <= tx_d;
      ack_q     <= ack_d;
      cbc_q     <= cbc_d;
    end
  end

  // Gated with rst_n so the uart never sees a ready while reset is held.
  assign s_axis_tready   = rst_n && ((state_q == StIdle) || (state_q == StRxKey) ||
                                     (state_q == StRxIv) || (state_q == StRxBlk));
  assign m_axis_tvalid   = (state_q == StTxBlk) || (state_q == StTxAck);
  assign m_axis_tdata    = (state_q == StTxAck) ? ack_q : tx_q[BLOCK_W-1 -: 8];
  assign c_m_axis_tvalid = (state_q == StCiphSend);
  assign c_m_axis_tdata  = blk_q;
  assign c_s_axis_tready = (state_q == StCiphWait);
  assign key             = key_q;
  assign key_update      = key_upd_q;

endmodule
